display_scan_mux: RTL and testbench
===================================

Name: display_scan_mux

Overview:
- Time-multiplexed driver for a bank of common-anode 7-segment digits.
- Takes a packed hex value plus per-digit blank and decimal-point masks, and scans one digit at a time at a programmable refresh rate.
- Double-buffers its inputs so a new value appears whole, at a frame boundary, with no tearing.
- Sits between the datapath (counters, ALU results) and the board's segment/anode pins.

Parameters:
- DIGITS, 4, number of digits scanned (1..8).
- SLOT_CYCLES, 100000, clk cycles per digit slot (>=2).
- GUARD_CYCLES, 1, cycles at the start of each slot with all anodes off, for anti-ghosting (< SLOT_CYCLES).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- value  in  4*DIGITS  hex nibbles; nibble i (bits 4i+3:4i) is shown on digit i; digit 0 is rightmost.
- blank  in  DIGITS  1 = digit i dark.
- dp  in  DIGITS  1 = decimal point lit on digit i.
- load  in  1  single-cycle strobe that captures value, blank and dp into the pending buffer.
- busy  out  1  1 while a captured load has not yet been applied to the display.
- frame_start  out  1  one-cycle pulse when digit 0's slot begins.
- seg  out  7  active-low segments, bit6..bit0 = g,f,e,d,c,b,a.
- dp_n  out  1  active-low decimal point.
- an  out  DIGITS  active-low anodes, bit i = digit i.

Behaviour:
- Reset is asynchronous and active-high: clk single clock, rst asynchronous, active-high.
- Reset values: seg=7'h7F, dp_n=1, an=all 1, busy=0, frame_start=0.
- Reset values, internal state: slot counter=0, digit index=0, active buffer = value 0, blank all 1, dp 0. After reset the display is dark until the first load has been applied.
- Slot counter:
  - Counts 0..SLOT_CYCLES-1.
  - On wrap, the digit index increments, and goes from DIGITS-1 back to 0.
- Frame boundary: the cycle in which the counter wraps while the index is DIGITS-1.
  - If pending is valid, pending is copied to active and busy clears on the next edge.
  - frame_start is asserted on the following cycle (counter=0, index=0).
- load:
  - Captures the inputs into the pending buffer and sets busy=1 on the next edge.
  - A load while busy=1 overwrites pending (last writer wins); busy stays 1.
  - load coincident with a frame boundary: the copy uses the old pending contents, and the new capture becomes pending with busy=1.
- Outputs are registered (one-cycle latency from counter/index to pins).
  - While counter < GUARD_CYCLES: an=all 1.
  - Otherwise an has only bit idx low, unless blank[idx]=1, in which case an=all 1.
  - seg and dp_n reflect digit idx throughout the slot.
- Hex decode, active low:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
  - Note 8 is explicitly 00 (all segments lit).
- All widths are derived from DIGITS via $clog2. The index compare uses DIGITS-1 so that non-power-of-two counts wrap correctly. With DIGITS=1, an never changes bit position.
- rst asserted mid-frame immediately forces the reset values, whatever the counter state. Pending contents are discarded.

Decomposition:
- display_pkg holds:
  - SEG_* localparams for the 16 glyphs and SEG_OFF=7'h7F.
  - A hex_to_seg function.
  - The segment bit-order constants.
- One sub-module, seg_hex_decoder: a combinational nibble-to-seg lookup using the package function. It is instantiated once on the muxed nibble.

Test Plan:
1. Reset then check pins: assert rst for 3 cycles -> seg=7F, dp_n=1, an=F, busy=0 during and after reset, and the display stays dark for a full frame.
2. Load and scan: DIGITS=4, SLOT_CYCLES=4, GUARD=1; load value=16'h1A8F, blank=0, dp=4'b0010 -> busy=1 until the frame boundary. Next frame shows:
   - an=E with seg=0E (F)
   - an=D with seg=00 and dp_n=0 (8)
   - an=B with seg=08 (A)
   - an=7 with seg=79 (1)
   In each slot, the first cycle has an=F.
3. Blanking: load blank=4'b1000 -> digit 3's slot keeps an=F throughout; the other digits are unaffected.
4. Tear-free update: issue load 16'h1234 mid-frame, then load 16'h5678 before the boundary -> 1234 is never displayed, the next frame shows 5678 in full, and busy drops exactly once.
5. Load on the boundary: assert load in the frame-boundary cycle -> the previously pending value goes live, busy stays 1, and the new value goes live one frame later.
6. Reset mid-operation plus a non-power-of-two count: DIGITS=3; assert rst while idx=2 and counter=2 -> outputs are reset immediately. After release the index sequence is 0,1,2,0, and frame_start pulses every 3*SLOT_CYCLES cycles.

Source files
------------

// File: rtl/display_pkg.sv
// Shared constants for the 7-segment scan driver: glyph encodings, segment bit
// positions and the hex-to-segment lookup.
package display_pkg;

  // Bit position of each segment inside the 7-bit seg bus (bit6..bit0 = g..a).
  localparam int unsigned SEG_BIT_A = 0;
  localparam int unsigned SEG_BIT_B = 1;
  localparam int unsigned SEG_BIT_C = 2;
  localparam int unsigned SEG_BIT_D = 3;
  localparam int unsigned SEG_BIT_E = 4;
  localparam int unsigned SEG_BIT_F = 5;
  localparam int unsigned SEG_BIT_G = 6;

  // Active-low glyphs for the hex digits.
  localparam logic [6:0] SEG_0   = 7'h40;
  localparam logic [6:0] SEG_1   = 7'h79;
  localparam logic [6:0] SEG_2   = 7'h24;
  localparam logic [6:0] SEG_3   = 7'h30;
  localparam logic [6:0] SEG_4   = 7'h19;
  localparam logic [6:0] SEG_5   = 7'h12;
  localparam logic [6:0] SEG_6   = 7'h02;
  localparam logic [6:0] SEG_7   = 7'h78;
  localparam logic [6:0] SEG_8   = 7'h00;
  localparam logic [6:0] SEG_9   = 7'h10;
  localparam logic [6:0] SEG_HA  = 7'h08;
  localparam logic [6:0] SEG_HB  = 7'h03;
  localparam logic [6:0] SEG_HC  = 7'h46;
  localparam logic [6:0] SEG_HD  = 7'h21;
  localparam logic [6:0] SEG_HE  = 7'h06;
  localparam logic [6:0] SEG_HF  = 7'h0E;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    logic [6:0] glyph;
    unique case (nibble)
      4'h0: glyph = SEG_0;
      4'h1: glyph = SEG_1;
      4'h2: glyph = SEG_2;
      4'h3: glyph = SEG_3;
      4'h4: glyph = SEG_4;
      4'h5: glyph = SEG_5;
      4'h6: glyph = SEG_6;
      4'h7: glyph = SEG_7;
      4'h8: glyph = SEG_8;
      4'h9: glyph = SEG_9;
      4'hA: glyph = SEG_HA;
      4'hB: glyph = SEG_HB;
      4'hC: glyph = SEG_HC;
      4'hD: glyph = SEG_HD;
      4'hE: glyph = SEG_HE;
      default: glyph = SEG_HF;
    endcase
    return glyph;
  endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational nibble-to-glyph lookup (active-low segments).
module seg_hex_decoder
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb seg = hex_to_seg(nibble);

endmodule

// File: rtl/display_scan_mux.sv
// Time-multiplexed common-anode 7-segment driver with a double-buffered
// value/blank/dp set that only changes at frame boundaries.
module display_scan_mux
  import display_pkg::*;
#(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned SLOT_CYCLES  = 100000,
  parameter int unsigned GUARD_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     blank,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  load,
  output logic                  busy,
  output logic                  frame_start,
  output logic [6:0]            seg,
  output logic                  dp_n,
  output logic [DIGITS-1:0]     an
);

  localparam int unsigned CW = $clog2(SLOT_CYCLES);
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  wrap, last_digit, boundary;

  logic [4*DIGITS-1:0]   pend_value_q, act_value_q;
  logic [DIGITS-1:0]     pend_blank_q, act_blank_q;
  logic [DIGITS-1:0]     pend_dp_q, act_dp_q;
  logic                  busy_q;

  logic [3:0]            nibble;
  logic [6:0]            seg_d, seg_q;
  logic                  dp_n_d, dp_n_q;
  logic [DIGITS-1:0]     an_d, an_q;
  logic                  frame_start_q;

  always_comb begin
    wrap       = (cnt_q == CW'(SLOT_CYCLES - 1));
    last_digit = (idx_q == IW'(DIGITS - 1));
    boundary   = wrap && last_digit;
    cnt_d      = wrap ? '0 : cnt_q + CW'(1);
    idx_d      = idx_q;
    if (wrap) begin
      idx_d = last_digit ? '0 : idx_q + IW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  // A load in the boundary cycle wins the pending slot; the copy still sees
  // the old pending contents because both read the pre-edge registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_value_q <= '0;
      pend_blank_q <= '1;
      pend_dp_q    <= '0;
      act_value_q  <= '0;
      act_blank_q  <= '1;
      act_dp_q     <= '0;
      busy_q       <= 1'b0;
    end else begin
      if (boundary && busy_q) begin
        act_value_q <= pend_value_q;
        act_blank_q <= pend_blank_q;
        act_dp_q    <= pend_dp_q;
        busy_q      <= 1'b0;
      end
      if (load) begin
        pend_value_q <= value;
        pend_blank_q <= blank;
        pend_dp_q    <= dp;
        busy_q       <= 1'b1;
      end
    end
  end

  always_comb nibble = act_value_q[{idx_q, 2'b00} +: 4];

  seg_hex_decoder u_decoder (
    .nibble (nibble),
    .seg    (seg_d)
  );

  always_comb begin
    dp_n_d = ~act_dp_q[idx_q];
    an_d   = '1;
    // Guard interval keeps anodes off while segments settle to the new digit.
    if ((cnt_q >= CW'(GUARD_CYCLES)) && !act_blank_q[idx_q]) begin
      an_d[idx_q] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q         <= SEG_OFF;
      dp_n_q        <= 1'b1;
      an_q          <= '1;
      frame_start_q <= 1'b0;
    end else begin
      seg_q         <= seg_d;
      dp_n_q        <= dp_n_d;
      an_q          <= an_d;
      frame_start_q <= boundary;
    end
  end

  assign seg         = seg_q;
  assign dp_n        = dp_n_q;
  assign an          = an_q;
  assign busy        = busy_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_display_scan_mux.sv
// Self-checking bench: a 4-digit and a 3-digit scanner run side by side against
// a cycle-count based reference model of the display behaviour.
module tb_display_scan_mux;

  localparam int SLOT  = 4;
  localparam int GUARD = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rst3 = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  blank = '0;
  logic [3:0]  dp = '0;

  logic        busy4, fs4, dpn4, busy3, fs3, dpn3;
  logic [6:0]  seg4, seg3;
  logic [3:0]  an4;
  logic [2:0]  an3;

  always #5 clk = ~clk;

  display_scan_mux #(.DIGITS(4), .SLOT_CYCLES(SLOT), .GUARD_CYCLES(GUARD)) dut4 (
    .clk(clk), .rst(rst), .value(value), .blank(blank), .dp(dp), .load(load),
    .busy(busy4), .frame_start(fs4), .seg(seg4), .dp_n(dpn4), .an(an4)
  );

  display_scan_mux #(.DIGITS(3), .SLOT_CYCLES(SLOT), .GUARD_CYCLES(GUARD)) dut3 (
    .clk(clk), .rst(rst3), .value(value[11:0]), .blank(blank[2:0]), .dp(dp[2:0]),
    .load(load), .busy(busy3), .frame_start(fs3), .seg(seg3), .dp_n(dpn3), .an(an3)
  );

  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int checks = 0;
  int errors = 0;

  // Reference model: position in the scan is derived from edges since reset.
  int          nd [2] = '{4, 3};
  int          n [2];
  logic [15:0] act_val [2], pend_val [2];
  logic [3:0]  act_bl [2], pend_bl [2], act_dp [2], pend_dp [2];
  bit          mbusy [2];
  logic [6:0]  e_seg [2];
  logic [3:0]  e_an [2];
  bit          e_dpn [2], e_fs [2];

  int cyc = 0;
  int drops = 0;
  bit prev_busy4 = 1'b0;
  int fs_last = -1;
  int fs3_count = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] mask(input int k);
    return 4'((1 << nd[k]) - 1);
  endfunction

  task automatic model_reset(input int k);
    n[k] = 0;
    act_val[k] = '0;
    act_bl[k] = mask(k);
    act_dp[k] = '0;
    mbusy[k] = 1'b0;
    e_seg[k] = 7'h7F;
    e_dpn[k] = 1'b1;
    e_an[k] = mask(k);
    e_fs[k] = 1'b0;
  endtask

  task automatic model_edge(input int k);
    int cnt, idx;
    bit bnd;
    cnt = n[k] % SLOT;
    idx = (n[k] / SLOT) % nd[k];
    bnd = (cnt == SLOT - 1) && (idx == nd[k] - 1);
    e_seg[k] = glyph[4'(act_val[k] >> (4 * idx))];
    e_dpn[k] = !act_dp[k][idx];
    e_an[k] = (cnt < GUARD || act_bl[k][idx]) ? mask(k) : (mask(k) & ~(4'(1) << idx));
    e_fs[k] = bnd;
    if (bnd && mbusy[k]) begin
      act_val[k] = pend_val[k];
      act_bl[k] = pend_bl[k];
      act_dp[k] = pend_dp[k];
      mbusy[k] = 1'b0;
    end
    if (load) begin
      pend_val[k] = (k == 1) ? (value & 16'h0FFF) : value;
      pend_bl[k] = blank & mask(k);
      pend_dp[k] = dp & mask(k);
      mbusy[k] = 1'b1;
    end
    n[k]++;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset(0); else model_edge(0);
    if (rst3) model_reset(1); else model_edge(1);
    #1;
    cyc++;
    chk("seg4", 32'(seg4), 32'(e_seg[0]));
    chk("an4", 32'(an4), 32'(e_an[0]));
    chk("dp_n4", 32'(dpn4), 32'(e_dpn[0]));
    chk("busy4", 32'(busy4), 32'(mbusy[0]));
    chk("frame_start4", 32'(fs4), 32'(e_fs[0]));
    chk("seg3", 32'(seg3), 32'(e_seg[1]));
    chk("an3", 32'(an3), 32'(e_an[1]));
    chk("dp_n3", 32'(dpn3), 32'(e_dpn[1]));
    chk("busy3", 32'(busy3), 32'(mbusy[1]));
    chk("frame_start3", 32'(fs3), 32'(e_fs[1]));
    if (prev_busy4 && !busy4) drops++;
    prev_busy4 = busy4;
    if (fs3) begin
      fs3_count++;
      if (fs_last >= 0) chk("frame_start3_period", 32'(cyc - fs_last), 32'd12);
      fs_last = cyc;
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] b, input logic [3:0] d);
    value = v;
    blank = b;
    dp = d;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  initial begin
    model_reset(0);
    model_reset(1);

    // Reset: pins go dark asynchronously, before any clock edge.
    #2;
    rst = 1'b1;
    rst3 = 1'b1;
    #1;
    chk("rst_seg", 32'(seg4), 32'h7F);
    chk("rst_an", 32'(an4), 32'hF);
    chk("rst_dp_n", 32'(dpn4), 32'd1);
    chk("rst_busy", 32'(busy4), 32'd0);
    repeat (3) tick();
    rst = 1'b0;
    rst3 = 1'b0;
    repeat (16) tick();

    // Load and scan.
    do_load(16'h1A8F, 4'b0000, 4'b0010);
    chk("busy_after_load", 32'(busy4), 32'd1);
    repeat (40) tick();

    // Blanking of digit 3.
    do_load(16'h1A8F, 4'b1000, 4'b0010);
    repeat (40) tick();

    // Tear-free double load within one frame.
    for (int i = 0; i < 16 && (n[0] % 16) != 3; i++) tick();
    drops = 0;
    do_load(16'h1234, 4'b0000, 4'b0000);
    repeat (4) tick();
    do_load(16'h5678, 4'b0000, 4'b0000);
    repeat (40) tick();
    chk("busy_drops", 32'(drops), 32'd1);

    // Load coincident with the frame boundary.
    for (int i = 0; i < 16 && (n[0] % 16) != 10; i++) tick();
    do_load(16'hC0DE, 4'b0000, 4'b0100);
    for (int i = 0; i < 16 && (n[0] % 16) != 15; i++) tick();
    do_load(16'hBEEF, 4'b0000, 4'b0001);
    chk("busy_after_boundary_load", 32'(busy4), 32'd1);
    repeat (40) tick();

    // Mid-frame reset of the 3-digit scanner at idx=2, counter=2.
    for (int i = 0; i < 12 && (n[1] % 12) != 10; i++) tick();
    #2;
    rst3 = 1'b1;
    #1;
    chk("midrst_seg3", 32'(seg3), 32'h7F);
    chk("midrst_an3", 32'(an3), 32'h7);
    chk("midrst_dp_n3", 32'(dpn3), 32'd1);
    chk("midrst_busy3", 32'(busy3), 32'd0);
    chk("midrst_fs3", 32'(fs3), 32'd0);
    model_reset(1);
    fs_last = -1;
    repeat (2) tick();
    rst3 = 1'b0;
    fs3_count = 0;
    do_load(16'h0321, 4'b0000, 4'b0000);
    repeat (48) tick();
    chk("frame_start3_count", 32'(fs3_count), 32'd4);

    // Randomized loads at random phases.
    repeat (30) begin
      repeat ($urandom_range(0, 20)) tick();
      do_load(16'($urandom), 4'($urandom), 4'($urandom));
    end
    repeat (40) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
